amo_sequencer: RTL and testbench

Multi-cycle controller for RV32A atomics: LR.W, SC.W and the AMO*.W read-modify-write operations.
- Triggered by the decoder's is_atomic flag in the execute stage.
- Sequences the data-memory port through a read phase and a write phase.
- Holds the LR/SC reservation.
- Stalls the pipeline until the result is ready for writeback.

---
 rtl/amo_pkg.sv | 40 ++++
 rtl/amo_alu.sv | 39 +++
 rtl/amo_sequencer.sv | 147 ++++++++++++++
 tb/tb_amo_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/amo_pkg.sv
// Shared types and decode helpers for the RV32A atomic sequencer.
// AMO_MINMAX_EN adds MIN/MAX/MINU/MAXU to the supported funct5 set.
package amo_pkg;

  localparam logic [6:0] AMO_OPCODE = 7'b0101111;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SWAP = 5'b00001,
    OP_LR   = 5'b00010,
    OP_SC   = 5'b00011,
    OP_XOR  = 5'b00100,
    OP_OR   = 5'b01000,
    OP_AND  = 5'b01100,
    OP_MIN  = 5'b10000,
    OP_MAX  = 5'b10100,
    OP_MINU = 5'b11000,
    OP_MAXU = 5'b11100
  } amo_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } amo_state_e;

  function automatic logic amo_supported(input logic [4:0] f);
    logic ok;
    case (f)
      OP_ADD, OP_SWAP, OP_LR, OP_SC, OP_XOR, OP_OR, OP_AND: ok = 1'b1;
`ifdef AMO_MINMAX_EN
      OP_MIN, OP_MAX, OP_MINU, OP_MAXU:                     ok = 1'b1;
`endif
      default:                                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational read-modify-write function f(old, rs2) for AMO*.W.
// Min/max comparators exist only when AMO_MINMAX_EN is defined.
module amo_alu
  import amo_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [4:0]      i_funct5,
  output logic [XLEN-1:0] o_result
);

`ifdef AMO_MINMAX_EN
  logic w_lt_s;
  logic w_lt_u;
  assign w_lt_s = $signed(i_old) < $signed(i_rs2);
  assign w_lt_u = i_old < i_rs2;
`endif

  always_comb begin
    o_result = i_rs2;
    case (i_funct5)
      OP_ADD:  o_result = i_old + i_rs2;
      OP_SWAP: o_result = i_rs2;
      OP_XOR:  o_result = i_old ^ i_rs2;
      OP_OR:   o_result = i_old | i_rs2;
      OP_AND:  o_result = i_old & i_rs2;
`ifdef AMO_MINMAX_EN
      OP_MIN:  o_result = w_lt_s ? i_old : i_rs2;
      OP_MAX:  o_result = w_lt_s ? i_rs2 : i_old;
      OP_MINU: o_result = w_lt_u ? i_old : i_rs2;
      OP_MAXU: o_result = w_lt_u ? i_rs2 : i_old;
`endif
      default: o_result = i_rs2;
    endcase
  end

endmodule

// File: rtl/amo_sequencer.sv
// Multi-cycle LR.W / SC.W / AMO*.W controller: sequences the data port, holds the
// LR/SC reservation and stalls EX. Min/max support follows AMO_MINMAX_EN (see amo_pkg).
module amo_sequencer
  import amo_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        funct5,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              resv_clear,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic              fault
);

  amo_state_e        r_state;
  amo_state_e        w_next;
  logic [4:0]        r_funct5;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_rs2;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_result;
  logic              r_fault;
  logic              r_resv_valid;
  logic [ADDR_W-1:0] r_resv_addr;

  logic              w_start_idle;
  logic              w_bad;
  logic              w_is_sc;
  logic              w_lr_pending;
  logic              w_lr_set;
  logic [ADDR_W-1:0] w_resv_tag;
  logic              w_snoop_hit;
  logic              w_sc_ok;
  logic [XLEN-1:0]   w_alu_out;
  logic              w_unused_snoop_lsb;

  assign w_start_idle = start && (r_state == IDLE);
  assign w_bad        = (addr[1:0] != 2'b00) || !amo_supported(funct5);
  assign w_is_sc      = (funct5 == OP_SC);
  assign w_lr_pending = (r_funct5 == OP_LR);
  assign w_lr_set     = (r_state == READ) && mem_ack && w_lr_pending;

  // Snoops compare against the address being reserved this cycle, if any.
  assign w_resv_tag   = w_lr_set ? r_addr : r_resv_addr;
  assign w_snoop_hit  = snoop_we && (snoop_addr[ADDR_W-1:2] == w_resv_tag[ADDR_W-1:2]);
  assign w_sc_ok      = r_resv_valid && (r_resv_addr == addr) && !w_snoop_hit && !resv_clear;
  assign w_unused_snoop_lsb = ^snoop_addr[1:0];

  amo_alu #(.XLEN(XLEN)) u_alu (
    .i_old    (mem_rdata),
    .i_rs2    (r_rs2),
    .i_funct5 (r_funct5),
    .o_result (w_alu_out)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_bad)        w_next = DONE;
          else if (w_is_sc) w_next = w_sc_ok ? WRITE : DONE;
          else              w_next = READ;
        end
      end
      READ:    if (mem_ack) w_next = w_lr_pending ? DONE : WRITE;
      WRITE:   if (mem_ack) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_funct5     <= '0;
      r_addr       <= '0;
      r_rs2        <= '0;
      r_wdata      <= '0;
      r_result     <= '0;
      r_fault      <= 1'b0;
      r_resv_valid <= 1'b0;
      r_resv_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_funct5 <= funct5;
            r_addr   <= addr;
            r_rs2    <= rs2_data;
            r_wdata  <= rs2_data;
            r_fault  <= w_bad;
            r_result <= (!w_bad && w_is_sc && !w_sc_ok) ? {{(XLEN-1){1'b0}}, 1'b1} : '0;
          end
        end
        READ: begin
          if (mem_ack) begin
            r_result <= mem_rdata;
            if (!w_lr_pending) r_wdata <= w_alu_out;
          end
        end
        WRITE: begin
          if (mem_ack && (r_funct5 == OP_SC)) r_result <= '0;
        end
        default: ;
      endcase

      // Later assignments win: LR set < SC consume < snoop < resv_clear.
      if (w_lr_set) begin
        r_resv_valid <= 1'b1;
        r_resv_addr  <= r_addr;
      end
      if (w_start_idle && w_is_sc) r_resv_valid <= 1'b0;
      if (w_snoop_hit)             r_resv_valid <= 1'b0;
      if (resv_clear)              r_resv_valid <= 1'b0;
    end
  end

  assign mem_req   = (r_state == READ) || (r_state == WRITE);
  assign mem_we    = (r_state == WRITE);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign stall     = w_start_idle || mem_req;
  assign done      = (r_state == DONE);
  assign fault     = done && r_fault;
  assign result    = r_result;

endmodule

// File: tb/tb_amo_sequencer.sv
// Directed bench for amo_sequencer with a simple word memory that can insert ack wait states.
module tb_amo_sequencer;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [4:0]        funct5;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   rs2_data;
  logic              resv_clear;
  logic              snoop_we;
  logic [ADDR_W-1:0] snoop_addr;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ack;
  logic              stall;
  logic              done;
  logic [XLEN-1:0]   result;
  logic              fault;

  amo_sequencer #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .funct5(funct5), .addr(addr),
    .rs2_data(rs2_data), .resv_clear(resv_clear), .snoop_we(snoop_we),
    .snoop_addr(snoop_addr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .stall(stall), .done(done), .result(result), .fault(fault)
  );

  always #5 clk = ~clk;

  logic [XLEN-1:0] mem [0:1023];
  logic [3:0]      ack_delay = 4'd0;
  logic [3:0]      wait_left = 4'd0;
  logic            pl_we = 1'b0;
  logic [9:0]      pl_idx = '0;
  logic [XLEN-1:0] pl_data = '0;

  assign mem_ack   = mem_req && (wait_left == 4'd0);
  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_left <= ack_delay;
    else                     wait_left <= wait_left - 4'd1;
    if (pl_we)                             mem[pl_idx] <= pl_data;
    else if (mem_req && mem_we && mem_ack) mem[mem_addr[11:2]] <= mem_wdata;
  end

  // Request-stability monitor: while req is pending without ack, attributes must hold.
  int              unstable = 0;
  logic            p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [ADDR_W-1:0] p_addr = '0;
  logic [XLEN-1:0] p_wdata = '0;
  always @(negedge clk) begin
    if (p_req && !p_ack && mem_req &&
        (mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wdata))
      unstable <= unstable + 1;
    p_req <= mem_req; p_ack <= mem_ack; p_we <= mem_we;
    p_addr <= mem_addr; p_wdata <= mem_wdata;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_idx = a[11:2]; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic pulse_snoop(input logic [31:0] a);
    @(negedge clk);
    snoop_we = 1'b1; snoop_addr = a;
    @(negedge clk);
    snoop_we = 1'b0; snoop_addr = '0;
  endtask

  // Issues one op; lat = cycles from the start edge until done is seen (40 = timeout).
  task automatic run_op(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic req_seen, output logic flt,
                        output logic stall_bad);
    req_seen = 1'b0; stall_bad = 1'b0; flt = 1'b0; lat = 0;
    @(negedge clk);
    funct5 = f5; addr = a; rs2_data = d; start = 1'b1;
    #1;
    if (!stall) stall_bad = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (mem_req) req_seen = 1'b1;
      if (!stall)  stall_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (done) begin
      flt = fault;
      if (stall) stall_bad = 1'b1;
    end
  endtask

  int   lat;
  logic rq, fl, sb;
  int   guard;

  initial begin
    reset = 1'b1; start = 1'b0; funct5 = '0; addr = '0; rs2_data = '0;
    resv_clear = 1'b0; snoop_we = 1'b0; snoop_addr = '0;
    repeat (3) @(negedge clk);
    check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_done",    {31'd0, done},    32'd0);
    check_val("rst_fault",   {31'd0, fault},   32'd0);
    check_val("rst_result",  result,           32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_val("idle_stall",  {31'd0, stall},   32'd0);

    // AMOADD zero-wait
    preload(32'h100, 32'd5);
    run_op(5'b00000, 32'h100, 32'd3, lat, rq, fl, sb);
    check_val("add_lat",    lat,          32'd3);
    check_val("add_result", result,       32'd5);
    check_val("add_mem",    mem[32'h100 >> 2], 32'd8);
    check_val("add_stall",  {31'd0, sb},  32'd0);
    check_val("add_fault",  {31'd0, fl},  32'd0);

    // LR then SC success, then SC fail
    preload(32'h200, 32'hAA);
    run_op(5'b00010, 32'h200, 32'd0, lat, rq, fl, sb);
    check_val("lr_lat",    lat,    32'd2);
    check_val("lr_result", result, 32'hAA);
    run_op(5'b00011, 32'h200, 32'h55, lat, rq, fl, sb);
    check_val("sc_ok_lat",    lat,    32'd2);
    check_val("sc_ok_result", result, 32'd0);
    check_val("sc_ok_mem",    mem[32'h200 >> 2], 32'h55);
    run_op(5'b00011, 32'h200, 32'h99, lat, rq, fl, sb);
    check_val("sc2_lat",    lat,          32'd1);
    check_val("sc2_result", result,       32'd1);
    check_val("sc2_no_req", {31'd0, rq},  32'd0);
    check_val("sc2_mem",    mem[32'h200 >> 2], 32'h55);

    // Snoop to same word kills reservation
    run_op(5'b00010, 32'h200, 32'd0, lat, rq, fl, sb);
    check_val("lr2_result", result, 32'h55);
    pulse_snoop(32'h202);
    run_op(5'b00011, 32'h200, 32'h77, lat, rq, fl, sb);
    check_val("snp_result", result,      32'd1);
    check_val("snp_no_req", {31'd0, rq}, 32'd0);
    check_val("snp_mem",    mem[32'h200 >> 2], 32'h55);

    // Snoop to neighbouring word leaves reservation intact
    run_op(5'b00010, 32'h200, 32'd0, lat, rq, fl, sb);
    pulse_snoop(32'h204);
    run_op(5'b00011, 32'h200, 32'h66, lat, rq, fl, sb);
    check_val("snp_other_result", result, 32'd0);
    check_val("snp_other_mem",    mem[32'h200 >> 2], 32'h66);

    // resv_clear kills reservation
    run_op(5'b00010, 32'h200, 32'd0, lat, rq, fl, sb);
    @(negedge clk); resv_clear = 1'b1;
    @(negedge clk); resv_clear = 1'b0;
    run_op(5'b00011, 32'h200, 32'h11, lat, rq, fl, sb);
    check_val("rclr_result", result,      32'd1);
    check_val("rclr_no_req", {31'd0, rq}, 32'd0);

    // Wait states on both phases: AMOXOR
    preload(32'h104, 32'h0000F0F0);
    ack_delay = 4'd4;
    run_op(5'b00100, 32'h104, 32'h00000FF0, lat, rq, fl, sb);
    ack_delay = 4'd0;
    check_val("ws_lat",      lat,       32'd11);
    check_val("ws_result",   result,    32'h0000F0F0);
    check_val("ws_mem",      mem[32'h104 >> 2], 32'h0000FF00);
    check_val("ws_stable",   unstable,  32'd0);
    check_val("ws_stall",    {31'd0, sb}, 32'd0);

    // Other AMOs, zero-wait
    preload(32'h108, 32'h0C);
    run_op(5'b01000, 32'h108, 32'h03, lat, rq, fl, sb);
    check_val("or_mem", mem[32'h108 >> 2], 32'h0F);
    preload(32'h10C, 32'h0C);
    run_op(5'b01100, 32'h10C, 32'h06, lat, rq, fl, sb);
    check_val("and_mem", mem[32'h10C >> 2], 32'h04);
    preload(32'h110, 32'h1234);
    run_op(5'b00001, 32'h110, 32'hBEEF, lat, rq, fl, sb);
    check_val("swap_result", result, 32'h1234);
    check_val("swap_mem",    mem[32'h110 >> 2], 32'hBEEF);
    preload(32'h114, 32'hFFFFFFFF);
    run_op(5'b00000, 32'h114, 32'd2, lat, rq, fl, sb);
    check_val("add_wrap_mem", mem[32'h114 >> 2], 32'd1);

    // Misaligned AMOSWAP
    run_op(5'b00001, 32'h103, 32'h5, lat, rq, fl, sb);
    check_val("mis_lat",    lat,         32'd1);
    check_val("mis_fault",  {31'd0, fl}, 32'd1);
    check_val("mis_no_req", {31'd0, rq}, 32'd0);

    // Unsupported funct5
    run_op(5'b00101, 32'h100, 32'h5, lat, rq, fl, sb);
    check_val("unsup_fault",  {31'd0, fl}, 32'd1);
    check_val("unsup_no_req", {31'd0, rq}, 32'd0);

`ifdef AMO_MINMAX_EN
    preload(32'h120, 32'hFFFFFFFF);
    run_op(5'b10000, 32'h120, 32'd1, lat, rq, fl, sb);
    check_val("min_mem", mem[32'h120 >> 2], 32'hFFFFFFFF);
    preload(32'h124, 32'hFFFFFFFF);
    run_op(5'b11000, 32'h124, 32'd1, lat, rq, fl, sb);
    check_val("minu_mem", mem[32'h124 >> 2], 32'd1);
    preload(32'h128, 32'hFFFFFFFF);
    run_op(5'b10100, 32'h128, 32'd1, lat, rq, fl, sb);
    check_val("max_mem", mem[32'h128 >> 2], 32'd1);
    preload(32'h12C, 32'hFFFFFFFF);
    run_op(5'b11100, 32'h12C, 32'd1, lat, rq, fl, sb);
    check_val("maxu_mem", mem[32'h12C >> 2], 32'hFFFFFFFF);
`else
    run_op(5'b10000, 32'h120, 32'd1, lat, rq, fl, sb);
    check_val("min_off_fault",  {31'd0, fl}, 32'd1);
    check_val("min_off_no_req", {31'd0, rq}, 32'd0);
`endif

    // Reset in the middle of a WRITE
    preload(32'h300, 32'h11);
    run_op(5'b00010, 32'h300, 32'd0, lat, rq, fl, sb);
    check_val("lr3_result", result, 32'h11);
    ack_delay = 4'd6;
    @(negedge clk);
    funct5 = 5'b00000; addr = 32'h300; rs2_data = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(mem_req && mem_we) && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    check_val("rw_reached_write", {31'd0, mem_req && mem_we}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_val("rw_req",    {31'd0, mem_req}, 32'd0);
    check_val("rw_done",   {31'd0, done},    32'd0);
    check_val("rw_result", result,           32'd0);
    reset = 1'b0;
    ack_delay = 4'd0;
    @(negedge clk);
    check_val("rw_done2", {31'd0, done},  32'd0);
    check_val("rw_idle",  {31'd0, stall}, 32'd0);
    check_val("rw_mem",   mem[32'h300 >> 2], 32'h11);
    run_op(5'b00011, 32'h300, 32'h99, lat, rq, fl, sb);
    check_val("rw_sc_result", result,      32'd1);
    check_val("rw_sc_no_req", {31'd0, rq}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
